// File: rtl/mux_alu_b.sv
// ALU operand-B selector (rs2 / forwarded value / immediate) with an imm-select activity counter.
// Define MUX_ALU_B_PIPE_EN to add a registered output stage (1-cycle latency, outputs reset to 0).
module mux_alu_b #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  imm,
    input  logic             ALUSrc,
    input  logic [1:0]       fwd_sel,
    input  logic [XLEN-1:0]  fwd_exmem,
    input  logic [XLEN-1:0]  fwd_memwb,
    input  logic             in_valid,
    output logic [XLEN-1:0]  alu_b,
    output logic             out_valid,
    output logic             src_is_imm,
    output logic [CNT_W-1:0] imm_cnt
);

    logic [XLEN-1:0]  reg_b;
    logic [XLEN-1:0]  sel_b;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        reg_b = rs2;
        unique case (fwd_sel)
            2'b01:   reg_b = fwd_exmem;
            2'b10:   reg_b = fwd_memwb;
            default: reg_b = rs2;
        endcase
    end

    assign sel_b = ALUSrc ? imm : reg_b;

    // Free-running wrap counter; reset takes priority over a same-edge increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (in_valid && ALUSrc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign imm_cnt = cnt_q;

`ifdef MUX_ALU_B_PIPE_EN
    logic [XLEN-1:0] alu_b_q;
    logic            out_valid_q;
    logic            src_is_imm_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_b_q      <= '0;
            out_valid_q  <= 1'b0;
            src_is_imm_q <= 1'b0;
        end else begin
            alu_b_q      <= sel_b;
            out_valid_q  <= in_valid;
            src_is_imm_q <= ALUSrc;
        end
    end

    assign alu_b      = alu_b_q;
    assign out_valid  = out_valid_q;
    assign src_is_imm = src_is_imm_q;
`else
    assign alu_b      = sel_b;
    assign out_valid  = in_valid;
    assign src_is_imm = ALUSrc;
`endif

endmodule

// File: tb/tb_mux_alu_b.sv
// Directed self-checking bench for mux_alu_b; follows MUX_ALU_B_PIPE_EN for output latency.
module tb_mux_alu_b;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  imm;
    logic             ALUSrc;
    logic [1:0]       fwd_sel;
    logic [XLEN-1:0]  fwd_exmem;
    logic [XLEN-1:0]  fwd_memwb;
    logic             in_valid;
    logic [XLEN-1:0]  alu_b;
    logic             out_valid;
    logic             src_is_imm;
    logic [CNT_W-1:0] imm_cnt;

    int n_total = 0;
    int n_bad   = 0;

    mux_alu_b #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs2        (rs2),
        .imm        (imm),
        .ALUSrc     (ALUSrc),
        .fwd_sel    (fwd_sel),
        .fwd_exmem  (fwd_exmem),
        .fwd_memwb  (fwd_memwb),
        .in_valid   (in_valid),
        .alu_b      (alu_b),
        .out_valid  (out_valid),
        .src_is_imm (src_is_imm),
        .imm_cnt    (imm_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge, so sampling stays clear of the active edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for the selected value to reach the outputs in either build.
    task automatic settle();
`ifdef MUX_ALU_B_PIPE_EN
        tick(1);
`else
        #1;
`endif
    endtask

    task automatic chk_sel(input string tag, input logic [31:0] exp_b, input logic exp_imm);
        settle();
        chk({tag, "_b"}, alu_b, exp_b);
        chk({tag, "_src"}, 32'(src_is_imm), 32'(exp_imm));
        chk({tag, "_vld"}, 32'(out_valid), 32'(in_valid));
    endtask

    initial begin
        rst_n     = 1'b0;
        rs2       = '0;
        imm       = '0;
        ALUSrc    = 1'b0;
        fwd_sel   = 2'b00;
        fwd_exmem = '0;
        fwd_memwb = '0;
        in_valid  = 1'b0;
        tick(2);
        chk("rst_cnt", 32'(imm_cnt), 32'd0);
`ifdef MUX_ALU_B_PIPE_EN
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
`endif
        rst_n = 1'b1;

        // Basic register / immediate selection
        in_valid = 1'b1;
        rs2 = 32'd50; imm = 32'd999; ALUSrc = 1'b0; fwd_sel = 2'b00;
        chk_sel("rs2", 32'd50, 1'b0);
        ALUSrc = 1'b1;
        chk_sel("imm", 32'd999, 1'b1);
        imm = 32'd1234;
        chk_sel("imm2", 32'd1234, 1'b1);

        // Forwarding overrides on the register path
        rs2 = 32'd7; fwd_exmem = 32'hAAAA_0001; fwd_memwb = 32'h5555_FFFE; ALUSrc = 1'b0;
        fwd_sel = 2'b01;
        chk_sel("fwd01", 32'hAAAA_0001, 1'b0);
        fwd_sel = 2'b10;
        chk_sel("fwd10", 32'h5555_FFFE, 1'b0);
        fwd_sel = 2'b11;
        chk_sel("fwd11", 32'd7, 1'b0);
        fwd_sel = 2'b00;
        chk_sel("fwd00", 32'd7, 1'b0);

        // Immediate wins regardless of fwd_sel; all bits copied unchanged
        ALUSrc = 1'b1; imm = 32'hFFFF_F800;
        for (int s = 0; s < 4; s++) begin
            fwd_sel = 2'(s);
            chk_sel($sformatf("immfwd%0d", s), 32'hFFFF_F800, 1'b1);
        end
        in_valid = 1'b0;
        chk_sel("vld0", 32'hFFFF_F800, 1'b1);
        in_valid = 1'b1;

        // Mid-stream reset with a valid imm select at the same edge
        tick(2);
        imm = 32'h1234_5678;
        rst_n = 1'b0;
        tick(1);
        chk("midrst_cnt", 32'(imm_cnt), 32'd0);
`ifdef MUX_ALU_B_PIPE_EN
        chk("midrst_b", alu_b, 32'd0);
        chk("midrst_vld", 32'(out_valid), 32'd0);
        chk("midrst_src", 32'(src_is_imm), 32'd0);
`else
        chk("midrst_b", alu_b, 32'h1234_5678);
        chk("midrst_vld", 32'(out_valid), 32'd1);
`endif
        rst_n = 1'b1;
        tick(1);
        chk("resume_cnt", 32'(imm_cnt), 32'd1);
        chk("resume_b", alu_b, 32'h1234_5678);
        chk("resume_vld", 32'(out_valid), 32'd1);

        // Counter: 5 imm cycles, 3 reg cycles
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1; in_valid = 1'b1; ALUSrc = 1'b1;
        tick(5);
        ALUSrc = 1'b0;
        tick(3);
        chk("cnt5", 32'(imm_cnt), 32'd5);
        in_valid = 1'b0; ALUSrc = 1'b1;
        tick(5);
        ALUSrc = 1'b0;
        tick(3);
        chk("cnt_novld", 32'(imm_cnt), 32'd5);

        // Wrap from all-ones to zero
        in_valid = 1'b1; ALUSrc = 1'b1;
        tick(65530);
        chk("cnt_max", 32'(imm_cnt), 32'h0000_FFFF);
        tick(1);
        chk("cnt_wrap", 32'(imm_cnt), 32'd0);
        tick(1);
        chk("cnt_after_wrap", 32'(imm_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
